// File: rtl/rf_pkg.sv
// Shared register-file types: geometry, address type and write-port scheduler states.
package rf_pkg;

  localparam int unsigned RF_DEPTH = 64;
  localparam int unsigned RF_AW    = 6;
  localparam int unsigned RF_NRD   = 7;

  typedef logic [RF_AW-1:0] rf_addr_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid index at or after ptr.
// ptr moves past the granted index only when the caller reports a transfer.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] valid,
  input  logic         advance,
  output logic [N-1:0] grant_c
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] idx;
  logic          found;

  // Cyclic priority search starting at ptr
  always_comb begin
    grant_c = '0;
    ptr_nxt = ptr;
    idx     = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr) + i) % N);
      if (!found && valid[idx]) begin
        found        = 1'b1;
        grant_c[idx] = 1'b1;
        ptr_nxt      = PW'((32'(idx) + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/rf_wport_sched.sv
// Register-file write-port scheduler: post-reset zero-fill sweep, round-robin
// writeback arbitration into a registered write stage, and read-port bypass.
module rf_wport_sched
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NREQ    = 4,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NREQ-1:0]                   req_valid_i,
  input  logic [NREQ-1:0][RF_AW-1:0]        req_addr_i,
  input  logic [NREQ-1:0][WIDTH-1:0]        req_data_i,
  output logic [NREQ-1:0]                   req_ready_o,
  output logic [RF_AW-1:0]                  ram_addrw_o,
  output logic [WIDTH-1:0]                  ram_din_o,
  output logic                              ram_wea_o,
  input  logic [RF_NRD-1:0][RF_AW-1:0]      rd_addr_i,
  input  logic [RF_NRD-1:0][WIDTH-1:0]      rd_raw_i,
  output logic [RF_NRD-1:0][WIDTH-1:0]      rd_data_o,
  output logic                              init_done_o
);

  rf_sched_state_e   state;
  rf_addr_t          cnt;
  logic [NREQ-1:0]   grant_c;
  logic              xfer_c;
  rf_addr_t          sel_addr_c;
  logic [WIDTH-1:0]  sel_data_c;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid_i),
    .advance (xfer_c),
    .grant_c (grant_c)
  );

  // Requesters are only served once the RAM has been zero-filled
  assign req_ready_o = (state == RUN) ? grant_c : '0;
  assign xfer_c      = |(req_valid_i & req_ready_o);

  always_comb begin
    sel_addr_c = '0;
    sel_data_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_ready_o[i]) begin
        sel_addr_c = req_addr_i[i];
        sel_data_c = req_data_i[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      cnt         <= '0;
      ram_wea_o   <= 1'b0;
      ram_addrw_o <= '0;
      ram_din_o   <= '0;
      init_done_o <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          ram_wea_o   <= 1'b1;
          ram_addrw_o <= cnt;
          ram_din_o   <= '0;
          cnt         <= cnt + rf_addr_t'(1);
          if (cnt == rf_addr_t'(RF_DEPTH - 1)) begin
            state       <= RUN;
            init_done_o <= 1'b1;
          end
        end
        RUN: begin
          // r0 writes are accepted but suppressed so the RAM keeps zero there
          ram_wea_o <= xfer_c && !(ZERO_R0 && (sel_addr_c == '0));
          if (xfer_c) begin
            ram_addrw_o <= sel_addr_c;
            ram_din_o   <= sel_data_c;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Forward the in-flight write so readers never see the pre-write RAM value
  for (genvar k = 0; k < RF_NRD; k++) begin : g_byp
    assign rd_data_o[k] = (ram_wea_o && (ram_addrw_o == rd_addr_i[k])) ? ram_din_o : rd_raw_i[k];
  end

endmodule

// File: tb/tb_rf_wport_sched.sv
// Bench for rf_wport_sched: expected RAM writes are queued by the stimulus and
// popped by a monitor whenever the write enable is seen; directed checks cover the rest.
module tb_rf_wport_sched;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NREQ  = 4;

  logic                        clk;
  logic                        rst_n;
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0][5:0]        req_addr;
  logic [NREQ-1:0][WIDTH-1:0]  req_data;
  logic [NREQ-1:0]             req_ready;
  logic [5:0]                  ram_addrw;
  logic [WIDTH-1:0]            ram_din;
  logic                        ram_wea;
  logic [6:0][5:0]             rd_addr;
  logic [6:0][WIDTH-1:0]       rd_raw;
  logic [6:0][WIDTH-1:0]       rd_data;
  logic                        init_done;

  typedef struct {
    logic [5:0]       a;
    logic [WIDTH-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;
  int  total = 0;
  int  bad   = 0;

  rf_wport_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .ZERO_R0(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .ram_addrw_o (ram_addrw),
    .ram_din_o   (ram_din),
    .ram_wea_o   (ram_wea),
    .rd_addr_i   (rd_addr),
    .rd_raw_i    (rd_raw),
    .rd_data_o   (rd_data),
    .init_done_o (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input int unsigned a, input logic [WIDTH-1:0] d);
    exp_q.push_back('{a: 6'(a), d: d});
  endtask

  // Monitor: every RAM write must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ram_wea === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr=%0d data=%0h, none expected", ram_addrw, ram_din);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(ram_addrw), 64'(e.a));
        check("wr_data", 64'(ram_din), 64'(e.d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rd_addr   = '0;
    rd_raw    = '0;
    // Source 2 is pending throughout the sweep and must not be accepted early
    req_valid    = 4'b0100;
    req_addr[2]  = 6'd5;
    req_data[2]  = 32'hDEADBEEF;
    rd_raw[0]    = 32'h55;
    #1 rst_n = 1'b0;
    #1;
    check("rst_wea", 64'(ram_wea), 64'd0);
    check("rst_addr", 64'(ram_addrw), 64'd0);
    check("rst_din", 64'(ram_din), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rd_passthru", 64'(rd_data[0]), 64'h55);

    for (int i = 0; i < 64; i++) push(i, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 63; i++) begin
      tick();
      check("sweep_ready", 64'(req_ready), 64'd0);
      check("sweep_init_done", 64'(init_done), 64'd0);
    end
    tick();
    #1;
    check("init_done_edge64", 64'(init_done), 64'd1);
    check("sweep_drained", 64'(exp_q.size()), 64'd0);
    check("first_grant_src2", 64'(req_ready), 64'b0100);
    push(5, 32'hDEADBEEF);

    // Cycle N+1: bypass must forward the in-flight write over stale RAM data
    tick();
    req_valid  = '0;
    rd_addr[3] = 6'd5;
    rd_raw[3]  = 32'h00000BAD;
    rd_addr[2] = 6'd6;
    rd_raw[2]  = 32'h66;
    #1;
    check("byp_wea", 64'(ram_wea), 64'd1);
    check("byp_addr", 64'(ram_addrw), 64'd5);
    check("byp_hit", 64'(rd_data[3]), 64'hDEADBEEF);
    check("byp_miss", 64'(rd_data[2]), 64'h66);

    // r0 write: accepted, suppressed, pointer still moves to 2
    req_valid   = 4'b0010;
    req_addr[1] = 6'd0;
    req_data[1] = 32'h1234;
    #1;
    check("r0_ready", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    #1;
    check("r0_no_wea", 64'(ram_wea), 64'd0);

    // All sources valid: grants rotate 2,3,0,1,...
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = 6'(8 + i);
      req_data[i] = 32'hA0 + 32'(i);
    end
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      check("rr_grant", 64'(req_ready), 64'(4'b0001 << ((2 + c) % 4)));
      push(8 + (2 + c) % 4, 32'hA0 + 32'((2 + c) % 4));
      tick();
    end
    req_valid = '0;

    // Move ptr to 0, then source 3 waits behind 0,1,2 with stable payload
    req_valid   = 4'b1000;
    req_addr[3] = 6'd39;
    req_data[3] = 32'h39;
    #1;
    check("solo_src3", 64'(req_ready), 64'b1000);
    push(39, 32'h39);
    tick();
    req_addr[3] = 6'd40;
    req_data[3] = 32'h33333333;
    req_valid   = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("stall_grant", 64'(req_ready), 64'(4'b0001 << c));
      if (c == 3) push(40, 32'h33333333);
      else        push(8 + c, 32'hA0 + 32'(c));
      tick();
      req_valid[c] = 1'b0;
    end
    tick();
    #1;
    check("run_drained", 64'(exp_q.size()), 64'd0);

    // Reset, then a second reset pulse landing at sweep address 30
    #1 rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("rst2_wea", 64'(ram_wea), 64'd0);
    check("rst2_init_done", 64'(init_done), 64'd0);
    check("rst2_ready", 64'(req_ready), 64'd0);
    for (int i = 0; i <= 30; i++) push(i, '0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 31; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wea", 64'(ram_wea), 64'd0);
    check("midrst_addr", 64'(ram_addrw), 64'd0);
    check("midrst_din", 64'(ram_din), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'd0);
    check("midrst_drained", 64'(exp_q.size()), 64'd0);
    req_valid = '0;
    for (int i = 0; i < 64; i++) push(i, '0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 63; i++) tick();
    #1;
    check("resweep_not_done", 64'(init_done), 64'd0);
    tick();
    #1;
    check("resweep_done", 64'(init_done), 64'd1);
    check("resweep_drained", 64'(exp_q.size()), 64'd0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
